uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_cfg.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state type,
// default clock/baud constants and the tick divider calculation.
package uart_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;
`endif

    // Rounded CLK_HZ / (BAUD * OVERSAMPLE); 64-bit to avoid overflow on fast clocks.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        longint den;
        den = baud * os;
        return int'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV enabled cycles,
// synchronous restart to count 0.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver writing bytes into a FIFO.
// Optional parity checking is enabled with the UART_RX_PARITY_EN macro.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       rx,
    output logic       wr_en,
    output logic [7:0] dout,
    input  logic       full,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    input  logic       parity_odd,
    output logic       parity_err,
`endif
    output rx_state_t  state_dbg
);

    // Write interface: wr_en is a one-cycle strobe and dout is valid while it
    // is high, holding until the next write. There is no backpressure: full
    // only turns the would-be write into a one-cycle overrun pulse.

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE + 1);

    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    rx_state_t     state_q, state_d;
    logic          rx_meta, rx_s, rx_prev;
    logic          tick, start_edge;
    logic [TW-1:0] tick_cnt, tick_next;
    logic          at_s0, at_mid, at_s2, bit_end;
    logic [1:0]    samp;
    logic          maj;
    logic [2:0]    bit_cnt;
    logic          stop_cnt;
    logic [7:0]    shreg, aligned;
    logic          wr_d, fe_d, ov_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, pe_d;
`endif

    assign state_dbg  = state_q;
    assign start_edge = (state_q == S_IDLE) && rx_prev && !rx_s;
    assign tick_next  = tick_cnt + TW'(1);
    assign at_s0      = tick && (tick_next == T_S0);
    assign at_mid     = tick && (tick_next == T_MID);
    assign at_s2      = tick && (tick_next == T_S2);
    assign bit_end    = tick && (tick_next == T_END);
    // Majority vote of the two stored samples and the third, live one.
    assign maj        = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign aligned    = shreg >> (8 - DATA_BITS);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud (
        .clk    (clk_50mhz),
        .rst    (rst),
        .en     (state_q != S_IDLE),
        .restart(start_edge),
        .tick   (tick)
    );

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_START;
            end
            S_START: begin
                if (at_mid && rx_s) state_d = S_IDLE;
                else if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (at_s2) begin
                    if (!maj) begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
                        pe_d    = par_bad;
`endif
                    end else if (stop_cnt == LAST_STOP) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) pe_d = 1'b1;
                        else if (full) ov_d = 1'b1;
                        else wr_d = 1'b1;
`else
                        if (full) ov_d = 1'b1;
                        else wr_d = 1'b1;
`endif
                    end
                end
            end
            S_BREAK: begin
                if (tick && rx_s && (tick_next == T_END)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            samp       <= '0;
            shreg      <= '0;
            wr_en      <= 1'b0;
            dout       <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;

            // In BREAK the tick counter measures continuous high time only.
            if (start_edge || (state_d == S_BREAK && state_q != S_BREAK)) begin
                tick_cnt <= '0;
            end else if (state_q == S_BREAK && !rx_s) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= (tick_next == T_END) ? '0 : tick_next;
            end

            if (start_edge) begin
                bit_cnt <= '0;
            end else if (state_q == S_DATA && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (start_edge) begin
                stop_cnt <= 1'b0;
            end else if (state_q == S_STOP && bit_end) begin
                stop_cnt <= 1'b1;
            end

            if (at_s0)  samp[0] <= rx_s;
            if (at_mid) samp[1] <= rx_s;

            if (state_q == S_DATA && at_s2) begin
                shreg <= {maj, shreg[7:1]};
            end

`ifdef UART_RX_PARITY_EN
            if (start_edge) begin
                par_bad <= 1'b0;
            end else if (state_q == S_PARITY && at_s2) begin
                par_bad <= maj != (^aligned ^ parity_odd);
            end
            parity_err <= pe_d;
`endif

            wr_en     <= wr_d;
            frame_err <= fe_d;
            overrun   <= ov_d;
            if (wr_d) dout <= aligned;
        end
    end

endmodule
